// File: rtl/a1339_spi_responder_pkg.sv
// Shared constants, FSM state type and response builder for the A1339
// SPI responder.
package a1339_responder_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned ADDR_W     = 6;
    localparam int unsigned PAYLOAD_W  = 12;

    localparam logic [ADDR_W-1:0] ADDR_ANGLE = 6'h20;
    localparam logic [ADDR_W-1:0] ADDR_TURNS = 6'h2E;
    localparam logic [ADDR_W-1:0] ADDR_TEST  = 6'h3E;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    // Response word: {err, 2'b00, odd parity over the whole word, payload}.
    function automatic logic [FRAME_BITS-1:0] build_response(
        input logic [ADDR_W-1:0]    addr,
        input logic [PAYLOAD_W-1:0] angle,
        input logic [PAYLOAD_W-1:0] turns,
        input logic [7:0]           test
    );
        logic                 err;
        logic [PAYLOAD_W-1:0] payload;
        err     = 1'b0;
        payload = '0;
        case (addr)
            ADDR_ANGLE: payload = angle;
            ADDR_TURNS: payload = turns;
            ADDR_TEST:  payload = {4'h0, test};
            default:    err     = 1'b1;
        endcase
        return {err, 2'b00, ~(^{err, payload}), payload};
    endfunction

endpackage

// File: rtl/a1339_spi_responder_if.sv
// 4-wire SPI bus between the sensor-interface master and the responder.
//   sck_i, ss_n_i, mosi_i : driven by the master
//   miso_o, miso_oe       : driven by the responder (miso_oe gates the tri-state)
interface a1339_spi_if;
    logic sck_i;
    logic ss_n_i;
    logic mosi_i;
    logic miso_o;
    logic miso_oe;

    modport master (
        output sck_i,
        output ss_n_i,
        output mosi_i,
        input  miso_o,
        input  miso_oe
    );

    modport slave (
        input  sck_i,
        input  ss_n_i,
        input  mosi_i,
        output miso_o,
        output miso_oe
    );
endinterface

// File: rtl/a1339_spi_responder_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection for one asynchronous input.
//   clock   : system clock
//   d_i     : asynchronous input
//   level_o : synchronized level
//   rise_c  : one-cycle pulse on a synchronized 0->1 transition
//   fall_c  : one-cycle pulse on a synchronized 1->0 transition
// The flops carry no reset so that a reset taken while the master is mid-frame
// does not fabricate an edge from the reset value.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic d_i,
    output logic level_o,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clock) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        prev_q <= sync_q[SYNC_STAGES-1];
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_c  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_c  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/a1339_spi_responder.sv
// SPI mode-3 slave emulating one A1339 angle sensor. Each 16-bit frame
// returns the answer to the previous frame's command address.
//   clock, reset : system clock (>= 8x sck), synchronous active-high reset
//   spi          : SPI bus (slave modport)
//   angle_i      : live angle served at address 0x20
//   turns_i      : live turns count served at address 0x2E
//   frame_done   : pulse when a 16-bit frame completes
//   frame_error  : pulse when a frame ends with a bit count other than 16
//   last_cmd     : last valid command word
//   test_reg     : scratch register at address 0x3E
module a1339_spi_responder
    import a1339_responder_pkg::*;
#(
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = 6'h20
) (
    input  logic                  clock,
    input  logic                  reset,
    a1339_spi_if.slave            spi,
    input  logic [PAYLOAD_W-1:0]  angle_i,
    input  logic [PAYLOAD_W-1:0]  turns_i,
    output logic                  frame_done,
    output logic                  frame_error,
    output logic [FRAME_BITS-1:0] last_cmd,
    output logic [7:0]            test_reg
);

    localparam int unsigned CNT_MAX = FRAME_BITS + 1;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic sck_rise_c, sck_fall_c, sck_level;
    logic ss_rise_c, ss_fall_c, ss_level_unused;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clock   (clock),
        .d_i     (spi.sck_i),
        .level_o (sck_level),
        .rise_c  (sck_rise_c),
        .fall_c  (sck_fall_c)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clock   (clock),
        .d_i     (spi.ss_n_i),
        .level_o (ss_level_unused),
        .rise_c  (ss_rise_c),
        .fall_c  (ss_fall_c)
    );

    // mosi only needs its synchronized level, sampled on sck rise.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clock   (clock),
        .d_i     (spi.mosi_i),
        .level_o (mosi_level),
        .rise_c  (mosi_rise_unused),
        .fall_c  (mosi_fall_unused)
    );

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]  rx_q, rx_d;
    logic [FRAME_BITS-1:0]  tx_q, tx_d;
    logic                   miso_q, miso_d;
    logic                   oe_q, oe_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [FRAME_BITS-1:0]  last_q, last_d;
    logic [7:0]             test_q, test_d;
    logic [ADDR_W-1:0]      pend_q, pend_d;
    logic                   fpend_q, fpend_d;
    logic                   tx_bit_c;
    logic                   sck_level_unused;

    assign sck_level_unused = sck_level;

    // Bit presented after an sck fall: index follows the received-bit count,
    // holding bit 0 once all 16 bits have been clocked.
    always_comb begin
        if (cnt_q >= CNT_W'(FRAME_BITS)) begin
            tx_bit_c = tx_q[0];
        end else begin
            tx_bit_c = tx_q[4'(FRAME_BITS - 1) - cnt_q[3:0]];
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            miso_q  <= 1'b1;
            oe_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= '0;
            test_q  <= '0;
            pend_q  <= RESET_ADDR;
            fpend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            miso_q  <= miso_d;
            oe_q    <= oe_d;
            done_q  <= done_d;
            err_q   <= err_d;
            last_q  <= last_d;
            test_q  <= test_d;
            pend_q  <= pend_d;
            fpend_q <= fpend_d;
        end
    end

    // Next-state and register updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        miso_d  = miso_q;
        oe_d    = oe_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        last_d  = last_q;
        test_d  = test_q;
        pend_d  = pend_q;
        fpend_d = fpend_q;

        case (state_q)
            IDLE: begin
                if (ss_fall_c || fpend_q) begin
                    tx_d    = build_response(pend_q, angle_i, turns_i, test_q);
                    miso_d  = tx_d[FRAME_BITS-1];
                    oe_d    = 1'b1;
                    cnt_d   = '0;
                    rx_d    = '0;
                    fpend_d = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // ss rise takes priority over any coincident sck edge.
                if (ss_rise_c) begin
                    state_d = DONE;
                end else if (sck_rise_c) begin
                    rx_d = {rx_q[FRAME_BITS-2:0], mosi_level};
                    if (cnt_q != CNT_W'(CNT_MAX)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (sck_fall_c) begin
                    miso_d = tx_bit_c;
                end
            end
            DONE: begin
                if (cnt_q == CNT_W'(FRAME_BITS)) begin
                    last_d = rx_q;
                    pend_d = rx_q[14:9];
                    if (rx_q[15] && (rx_q[14:9] == ADDR_TEST)) begin
                        test_d = rx_q[7:0];
                    end
                    done_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                // A new select arriving now is started from the next IDLE cycle.
                if (ss_fall_c) begin
                    fpend_d = 1'b1;
                end
                oe_d    = 1'b0;
                miso_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign spi.miso_o  = miso_q;
    assign spi.miso_oe = oe_q;
    assign frame_done  = done_q;
    assign frame_error = err_q;
    assign last_cmd    = last_q;
    assign test_reg    = test_q;

endmodule

// File: tb/tb_a1339_spi_responder.sv
// Scoreboard bench for the A1339 SPI responder: a mode-3 master task pushes
// the expected outcome of each frame, a monitor pops it on every done/error pulse.
module tb_a1339_spi_responder;

    localparam int HALF = 5;
    localparam int GAP  = 12;

    logic        clock;
    logic        reset;
    logic [11:0] angle_i;
    logic [11:0] turns_i;
    logic        frame_done;
    logic        frame_error;
    logic [15:0] last_cmd;
    logic [7:0]  test_reg;

    a1339_spi_if spi ();

    a1339_spi_responder #(
        .SYNC_STAGES (2),
        .RESET_ADDR  (6'h20)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .spi         (spi),
        .angle_i     (angle_i),
        .turns_i     (turns_i),
        .frame_done  (frame_done),
        .frame_error (frame_error),
        .last_cmd    (last_cmd),
        .test_reg    (test_reg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          is_done;
        logic [15:0] resp;
        logic [15:0] cmd;
        logic [7:0]  test;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] rx_word  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Mode-3 master: sck idles high, master drives mosi on fall, samples miso before rise.
    task automatic spi_xfer(input logic [15:0] word, input int nbits);
        logic [15:0] sh;
        logic [15:0] cap;
        sh  = word;
        cap = '0;
        @(negedge clock);
        spi.ss_n_i = 1'b0;
        repeat (HALF) @(negedge clock);
        for (int i = 0; i < nbits; i++) begin
            spi.sck_i  = 1'b0;
            spi.mosi_i = sh[15];
            sh         = {sh[14:0], 1'b0};
            repeat (HALF) @(negedge clock);
            cap       = {cap[14:0], spi.miso_o};
            spi.sck_i = 1'b1;
            repeat (HALF) @(negedge clock);
        end
        rx_word    = cap;
        spi.ss_n_i = 1'b1;
        repeat (GAP) @(negedge clock);
    endtask

    task automatic frame(input logic [15:0] word, input int nbits, input bit good,
                         input logic [15:0] resp, input logic [15:0] cmd, input logic [7:0] tst);
        exp_t e;
        e.is_done = good;
        e.resp    = resp;
        e.cmd     = cmd;
        e.test    = tst;
        sb_q.push_back(e);
        spi_xfer(word, nbits);
    endtask

    // Monitor: every done/error pulse must match the oldest expected frame.
    always @(negedge clock) begin
        if (frame_done || frame_error) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pulse: got done=%0b err=%0b expected none",
                         frame_done, frame_error);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("pulse_kind", {30'd0, frame_done, frame_error}, {30'd0, e.is_done, ~e.is_done});
                if (e.is_done) begin
                    check("miso_word", 32'(rx_word), 32'(e.resp));
                end
                check("last_cmd", 32'(last_cmd), 32'(e.cmd));
                check("test_reg", 32'(test_reg), 32'(e.test));
            end
        end
    end

    initial begin
        logic [15:0] sh;
        bit          oe_seen;
        reset      = 1'b1;
        spi.sck_i  = 1'b1;
        spi.ss_n_i = 1'b1;
        spi.mosi_i = 1'b0;
        angle_i    = 12'h5A3;
        turns_i    = 12'h007;
        repeat (5) @(negedge clock);
        check("rst_miso",     32'(spi.miso_o),  32'd1);
        check("rst_miso_oe",  32'(spi.miso_oe), 32'd0);
        check("rst_done",     32'(frame_done),  32'd0);
        check("rst_error",    32'(frame_error), 32'd0);
        check("rst_last_cmd", 32'(last_cmd),    32'd0);
        check("rst_test_reg", 32'(test_reg),    32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Reset-default address, then angle with parity set.
        frame(16'h4000, 16, 1'b1, 16'h15A3, 16'h4000, 8'h00);
        frame(16'h4000, 16, 1'b1, 16'h15A3, 16'h4000, 8'h00);
        // Turns read.
        frame(16'h5C00, 16, 1'b1, 16'h15A3, 16'h5C00, 8'h00);
        frame(16'h4000, 16, 1'b1, 16'h0007, 16'h4000, 8'h00);
        // Test register write, read back, dummy.
        frame(16'hFCC5, 16, 1'b1, 16'h15A3, 16'hFCC5, 8'hC5);
        frame(16'h7C00, 16, 1'b1, 16'h10C5, 16'h7C00, 8'hC5);
        frame(16'h4000, 16, 1'b1, 16'h10C5, 16'h4000, 8'hC5);
        // Unknown address.
        frame(16'h2200, 16, 1'b1, 16'h15A3, 16'h2200, 8'hC5);
        frame(16'h4000, 16, 1'b1, 16'h8000, 16'h4000, 8'hC5);
        // Short and long frames leave state untouched.
        frame(16'h5C00, 16, 1'b1, 16'h15A3, 16'h5C00, 8'hC5);
        frame(16'h7C00,  9, 1'b0, 16'h0000, 16'h5C00, 8'hC5);
        frame(16'hFC12, 17, 1'b0, 16'h0000, 16'h5C00, 8'hC5);
        frame(16'h4000, 16, 1'b1, 16'h0007, 16'h4000, 8'hC5);

        // Reset after 6 bits; the rest of the frame must be ignored.
        sh      = 16'h7C00;
        oe_seen = 1'b0;
        @(negedge clock);
        spi.ss_n_i = 1'b0;
        repeat (HALF) @(negedge clock);
        for (int i = 0; i < 16; i++) begin
            spi.sck_i  = 1'b0;
            spi.mosi_i = sh[15];
            sh         = {sh[14:0], 1'b0};
            repeat (HALF) @(negedge clock);
            if (i == 6) begin
                reset = 1'b1;
                repeat (3) @(negedge clock);
                check("midrst_oe", 32'(spi.miso_oe), 32'd0);
                reset = 1'b0;
            end
            if (i > 6 && spi.miso_oe) oe_seen = 1'b1;
            spi.sck_i = 1'b1;
            repeat (HALF) @(negedge clock);
        end
        spi.ss_n_i = 1'b1;
        repeat (GAP) @(negedge clock);
        check("midrst_oe_stays_low", 32'(oe_seen),      32'd0);
        check("midrst_last_cmd",     32'(last_cmd),     32'd0);
        check("midrst_test_reg",     32'(test_reg),     32'd0);

        angle_i = 12'h0FF;
        frame(16'h5C00, 16, 1'b1, 16'h10FF, 16'h5C00, 8'h00);
        frame(16'h4000, 16, 1'b1, 16'h0007, 16'h4000, 8'h00);

        for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(negedge clock);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d pending frames expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
